ascii_hex_parser: RTL and testbench
===================================

ASCII_HEX_PARSER -- requirements
Module: ascii_hex_parser

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 8, meaning the maximum hex digits per word (value width = 4*MAX_DIGITS).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port ascii_in, input, 8 bits: incoming ASCII character.
REQ-005 SHALL have port in_valid, input, 1 bit: ascii_in holds a character.
REQ-006 SHALL have port in_ready, output, 1 bit: parser accepts a character this cycle.
REQ-007 SHALL have port value, output, 4*MAX_DIGITS bits: parsed word, zero-extended on the left.
REQ-008 SHALL have port digit_count, output, 4 bits: number of digits forming value.
REQ-009 SHALL have port out_valid, output, 1 bit: value/digit_count are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer takes the word.
REQ-011 SHALL have port err, output, 1 bit: one-cycle error pulse.

Function
REQ-012 A character SHALL be accepted only on a rising edge where in_valid and in_ready are both 1.
REQ-013 Digit class SHALL be 0x30-0x39 (0-9), 0x41-0x46 (A-F), 0x61-0x66 (a-f), mapped to nibble 0x0-0xF; terminator class SHALL be 0x0D, 0x0A, 0x20; every other code is invalid.
REQ-014 States SHALL be IDLE (no digits), ACCUM (1..MAX_DIGITS digits held), DONE (word presented), SKIP (discarding a bad token).
REQ-015 in_ready SHALL be 1 in IDLE, ACCUM, SKIP and 0 in DONE, derived from state only.
REQ-016 IDLE: digit -> acc=nibble, count=1, go ACCUM; terminator -> ignored, stay IDLE; invalid -> err pulse, stay IDLE.
REQ-017 ACCUM: digit with count<MAX_DIGITS -> acc={acc shifted left 4, nibble}, count+1.
REQ-018 ACCUM: digit with count==MAX_DIGITS -> overflow: err pulse, acc/count cleared, go SKIP.
REQ-019 ACCUM: invalid character -> err pulse, acc/count cleared, go SKIP.
REQ-020 ACCUM: terminator -> value=acc, digit_count=count, out_valid=1 from the next cycle, go DONE.
REQ-021 SKIP: digits and invalid characters SHALL be consumed silently (no further err); terminator -> go IDLE.
REQ-022 DONE: out_valid, value, digit_count SHALL hold stable until a rising edge with out_ready=1; on that edge out_valid->0, acc/count cleared, go IDLE.
REQ-023 err SHALL be registered, asserted exactly the cycle after the offending character is accepted.
REQ-024 value and digit_count SHALL retain their last word after out_valid drops until the next word is latched.
REQ-025 Latency SHALL be one cycle: terminator accepted at edge N -> out_valid=1 after edge N.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, acc=0, count=0, value=0, digit_count=0, out_valid=0, err=0, hence in_ready=1.
REQ-027 Reset asserted mid-token (ACCUM, SKIP or DONE) SHALL discard the partial or pending word with no out_valid or err.
REQ-028 After rst_n deasserts, the first accepted character SHALL be processed from IDLE.

Verification
REQ-029 Send "1A3f\r" with out_ready=1 -> out_valid one cycle, value=0x00001A3F, digit_count=4, err never set.
REQ-030 Send "DEADBEEF\n" -> value=0xDEADBEEF, digit_count=8.
REQ-031 Send "123456789 7 " -> err pulse after 9th digit, no word for the first token, then value=0x00000007, digit_count=1.
REQ-032 Send "12G4 " -> single err pulse after 'G', no out_valid; following "5\r" -> value=0x00000005.
REQ-033 Send "AB\r" with out_ready=0 for 5 cycles -> in_ready=0, out_valid=1, value=0x000000AB stable; raise out_ready -> next cycle out_valid=0, in_ready=1.
REQ-034 Send "AB", pulse rst_n low, send "C\r" -> value=0x0000000C, digit_count=1, no err.

Source files
------------

// File: rtl/ascii_hex_parser_if.sv
// Character-in / word-out handshake bundle for the ASCII hex parser.
interface ascii_hex_parser_if #(
    parameter int MAX_DIGITS = 8
);
    logic [7:0]              ascii_in;
    logic                    in_valid;
    logic                    in_ready;
    logic [4*MAX_DIGITS-1:0] value;
    logic [3:0]              digit_count;
    logic                    out_valid;
    logic                    out_ready;
    logic                    err;

    modport master (
        output ascii_in, in_valid, out_ready,
        input  in_ready, value, digit_count, out_valid, err
    );

    modport slave (
        input  ascii_in, in_valid, out_ready,
        output in_ready, value, digit_count, out_valid, err
    );
endinterface

// File: rtl/ascii_hex_parser.sv
// Streams ASCII characters in and assembles whitespace/CR/LF-terminated hex
// tokens into words; bad or over-long tokens raise err and are discarded.
module ascii_hex_parser #(
    parameter int MAX_DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ascii_hex_parser_if.slave     bus
);
    localparam int W = 4 * MAX_DIGITS;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE, SKIP} state_e;

    state_e       state_q, state_d;
    logic [W-1:0] acc_q, acc_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [W-1:0] value_q, value_d;
    logic [3:0]   dcnt_q, dcnt_d;
    logic         ov_q, ov_d;
    logic         err_q, err_d;

    logic         is_dig, is_term, accept;
    logic [3:0]   nib;

    always_comb begin
        is_dig  = 1'b0;
        nib     = 4'h0;
        is_term = (bus.ascii_in == 8'h0D) || (bus.ascii_in == 8'h0A) ||
                  (bus.ascii_in == 8'h20);
        if (bus.ascii_in >= 8'h30 && bus.ascii_in <= 8'h39) begin
            is_dig = 1'b1;
            nib    = bus.ascii_in[3:0];
        end else if ((bus.ascii_in >= 8'h41 && bus.ascii_in <= 8'h46) ||
                     (bus.ascii_in >= 8'h61 && bus.ascii_in <= 8'h66)) begin
            // 'A'..'F' and 'a'..'f' share low bits 1..6
            is_dig = 1'b1;
            nib    = bus.ascii_in[3:0] + 4'd9;
        end
    end

    assign bus.in_ready    = (state_q != DONE);
    assign accept          = bus.in_valid && bus.in_ready;
    assign bus.value       = value_q;
    assign bus.digit_count = dcnt_q;
    assign bus.out_valid   = ov_q;
    assign bus.err         = err_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        dcnt_d  = dcnt_q;
        ov_d    = ov_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                if (is_dig) begin
                    acc_d   = W'(nib);
                    cnt_d   = 4'd1;
                    state_d = ACCUM;
                end else if (!is_term) begin
                    err_d = 1'b1;
                end
            end
            ACCUM: if (accept) begin
                if (is_dig && cnt_q < 4'(MAX_DIGITS)) begin
                    acc_d = (acc_q << 4) | W'(nib);
                    cnt_d = cnt_q + 4'd1;
                end else if (is_term) begin
                    value_d = acc_q;
                    dcnt_d  = cnt_q;
                    ov_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    // overflow or invalid: drop the token until a terminator
                    err_d   = 1'b1;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = SKIP;
                end
            end
            SKIP: if (accept && is_term) state_d = IDLE;
            DONE: if (bus.out_ready) begin
                ov_d    = 1'b0;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            value_q <= '0;
            dcnt_q  <= '0;
            ov_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            dcnt_q  <= dcnt_d;
            ov_q    <= ov_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_ascii_hex_parser.sv
// Directed bench for ascii_hex_parser: hand-computed words, err pulses, backpressure, reset.
module tb_ascii_hex_parser;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    ascii_hex_parser_if #(.MAX_DIGITS(8)) bus ();
    ascii_hex_parser #(.MAX_DIGITS(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Output monitor on the falling edge, away from the active edge.
    int          err_cnt = 0;
    int          ov_cycles = 0;
    logic        ov_prev = 1'b0;
    logic [31:0] wq_val[$];
    logic [3:0]  wq_cnt[$];
    always @(negedge clk) begin
        if (bus.err) err_cnt++;
        if (bus.out_valid) ov_cycles++;
        if (bus.out_valid && !ov_prev) begin
            wq_val.push_back(bus.value);
            wq_cnt.push_back(bus.digit_count);
        end
        ov_prev = bus.out_valid;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_char(input logic [7:0] c);
        int n;
        @(negedge clk);
        bus.ascii_in = c;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("in_ready_timeout", {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int e0, o0, w0;

    initial begin
        bus.ascii_in  = 8'h00;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #12;
        chk("rst_in_ready",  {63'd0, bus.in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_err",       {63'd0, bus.err}, 64'd0);
        chk("rst_value",     {32'd0, bus.value}, 64'd0);
        chk("rst_dcnt",      {60'd0, bus.digit_count}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // "1A3f\r": one-cycle latency, one-cycle out_valid with out_ready high
        e0 = err_cnt; o0 = ov_cycles; w0 = wq_val.size();
        send_str("1A3f");
        send_char(8'h0D);
        chk("t1_latency", {63'd0, bus.out_valid}, 64'd1);
        idle(3);
        chk("t1_words", 64'(wq_val.size() - w0), 64'd1);
        chk("t1_value", {32'd0, wq_val[$]}, 64'h1A3F);
        chk("t1_dcnt",  {60'd0, wq_cnt[$]}, 64'd4);
        chk("t1_ovcyc", 64'(ov_cycles - o0), 64'd1);
        chk("t1_err",   64'(err_cnt - e0), 64'd0);
        chk("t1_retain", {32'd0, bus.value}, 64'h1A3F);

        // full-width word
        w0 = wq_val.size();
        send_str("DEADBEEF");
        send_char(8'h0A);
        idle(2);
        chk("t2_words", 64'(wq_val.size() - w0), 64'd1);
        chk("t2_value", {32'd0, wq_val[$]}, 64'hDEADBEEF);
        chk("t2_dcnt",  {60'd0, wq_cnt[$]}, 64'd8);

        // 9-digit overflow, then a good token
        e0 = err_cnt; w0 = wq_val.size();
        send_str("12345678");
        chk("t3_no_err_at_8", {63'd0, bus.err}, 64'd0);
        send_char("9");
        chk("t3_err_pulse", {63'd0, bus.err}, 64'd1);
        send_str(" 7 ");
        idle(2);
        chk("t3_err_cnt", 64'(err_cnt - e0), 64'd1);
        chk("t3_words",   64'(wq_val.size() - w0), 64'd1);
        chk("t3_value",   {32'd0, wq_val[$]}, 64'h7);
        chk("t3_dcnt",    {60'd0, wq_cnt[$]}, 64'd1);

        // invalid mid-token: single err, rest swallowed
        e0 = err_cnt; w0 = wq_val.size();
        send_str("12G");
        chk("t4_err_pulse", {63'd0, bus.err}, 64'd1);
        send_str("4 ");
        idle(2);
        chk("t4_err_cnt", 64'(err_cnt - e0), 64'd1);
        chk("t4_no_word", 64'(wq_val.size() - w0), 64'd0);
        send_char("5");
        send_char(8'h0D);
        idle(2);
        chk("t4_value", {32'd0, wq_val[$]}, 64'h5);

        // invalid char from IDLE, terminator from IDLE ignored
        e0 = err_cnt; w0 = wq_val.size();
        send_char(" ");
        chk("t5_term_idle", {63'd0, bus.err}, 64'd0);
        send_char("x");
        chk("t5_inv_idle", {63'd0, bus.err}, 64'd1);
        idle(2);
        chk("t5_err_cnt", 64'(err_cnt - e0), 64'd1);
        chk("t5_no_word", 64'(wq_val.size() - w0), 64'd0);

        // backpressure
        bus.out_ready = 1'b0;
        send_str("AB");
        send_char(8'h0D);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_in_ready", {63'd0, bus.in_ready}, 64'd0);
            chk("t6_ovalid",   {63'd0, bus.out_valid}, 64'd1);
            chk("t6_value",    {32'd0, bus.value}, 64'hAB);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_release_ov", {63'd0, bus.out_valid}, 64'd0);
        chk("t6_release_rdy", {63'd0, bus.in_ready}, 64'd1);
        chk("t6_retain", {32'd0, bus.value}, 64'hAB);
        chk("t6_dcnt",   {60'd0, bus.digit_count}, 64'd2);

        // reset mid-token discards partial word
        e0 = err_cnt; o0 = ov_cycles;
        send_str("AB");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_value", {32'd0, bus.value}, 64'd0);
        chk("t7_rst_ready", {63'd0, bus.in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        chk("t7_no_ov", 64'(ov_cycles - o0), 64'd0);
        send_char("C");
        send_char(8'h0D);
        idle(2);
        chk("t7_value", {32'd0, wq_val[$]}, 64'hC);
        chk("t7_dcnt",  {60'd0, wq_cnt[$]}, 64'd1);
        chk("t7_err",   64'(err_cnt - e0), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
